// File: rtl/dircc_ring_pkg.sv
// Shared types for the dircc ring router: Avalon-ST beat record and the two
// controller state encodings.
package dircc_ring_pkg;

    localparam int ST_EMPTY_W = 2;

    typedef struct packed {
        logic [31:0]           data;
        logic                  sop;
        logic                  eop;
        logic [ST_EMPTY_W-1:0] empty;
    } st_beat_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LOCAL,
        R_PASS
    } ingress_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_PASS,
        A_LOCAL
    } arb_state_t;

endpackage

// File: rtl/dircc_st_reg_slice.sv
// One-deep registered Avalon-ST stage: accepts a beat whenever it is empty or
// being drained, giving one cycle of latency at full throughput.
module dircc_st_reg_slice
    import dircc_ring_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  st_beat_t in_beat,
    output logic     out_valid,
    output st_beat_t out_beat,
    input  logic     out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_beat <= in_beat;
            end
        end
    end

endmodule

// File: rtl/dircc_ring_router.sv
// Ring-node router: steers ring packets addressed to this node into the PE,
// forwards the rest, and merges PE packets onto the ring with packet-granular arbitration.
module dircc_ring_router
    import dircc_ring_pkg::*;
#(
    parameter int unsigned MAX_PASS_BURST = 4,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [31:0]               address_address,
    input  logic                      ring_in_valid,
    output logic                      ring_in_ready,
    input  logic [31:0]               ring_in_data,
    input  logic                      ring_in_startofpacket,
    input  logic                      ring_in_endofpacket,
    input  logic [ST_EMPTY_W-1:0]     ring_in_empty,
    input  logic                      local_in_valid,
    output logic                      local_in_ready,
    input  logic [31:0]               local_in_data,
    input  logic                      local_in_startofpacket,
    input  logic                      local_in_endofpacket,
    input  logic [ST_EMPTY_W-1:0]     local_in_empty,
    output logic                      local_out_valid,
    input  logic                      local_out_ready,
    output logic [31:0]               local_out_data,
    output logic                      local_out_startofpacket,
    output logic                      local_out_endofpacket,
    output logic [ST_EMPTY_W-1:0]     local_out_empty,
    output logic                      ring_out_valid,
    input  logic                      ring_out_ready,
    output logic [31:0]               ring_out_data,
    output logic                      ring_out_startofpacket,
    output logic                      ring_out_endofpacket,
    output logic [ST_EMPTY_W-1:0]     ring_out_empty,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_PASS_BURST);
    localparam int         DW1       = DROP_CNT_WIDTH + 1;

    ingress_state_t ring_state, ring_state_next;
    arb_state_t     arb_state, arb_state_next;
    logic [3:0]     burst_cnt, burst_cnt_next;
    logic [DROP_CNT_WIDTH-1:0] drop_next;

    st_beat_t ring_beat, local_beat, ro_in_beat, lo_out_beat, ro_out_beat;
    logic     lo_in_valid, lo_in_ready, ro_in_valid, ro_in_ready;
    logic     ring_hdr, hdr_local, ring_drop, local_drop, pass_req, local_req;
    logic     local_wins, pass_grant, local_grant, pass_xfer, local_xfer, ring_fire;
    logic [1:0]     drop_inc;
    logic [DW1-1:0] drop_sum;

    assign ring_beat  = {ring_in_data, ring_in_startofpacket, ring_in_endofpacket, ring_in_empty};
    assign local_beat = {local_in_data, local_in_startofpacket, local_in_endofpacket, local_in_empty};

    // Route decode and arbitration are combinational so a header transfers in the decision cycle.
    always_comb begin
        ring_hdr    = (ring_state == R_IDLE) && ring_in_valid && ring_in_startofpacket;
        hdr_local   = (ring_in_data == address_address);
        ring_drop   = (ring_state == R_IDLE) && ring_in_valid && !ring_in_startofpacket;
        lo_in_valid = ((ring_state == R_LOCAL) && ring_in_valid) || (ring_hdr && hdr_local);
        pass_req    = ((ring_state == R_PASS) && ring_in_valid) || (ring_hdr && !hdr_local);
        local_req   = local_in_valid && local_in_startofpacket;
        local_drop  = (arb_state == A_IDLE) && local_in_valid && !local_in_startofpacket;
        local_wins  = local_req && (!pass_req || (burst_cnt == BURST_MAX));
        pass_grant  = (arb_state == A_PASS) || ((arb_state == A_IDLE) && pass_req && !local_wins);
        local_grant = (arb_state == A_LOCAL) || ((arb_state == A_IDLE) && local_wins);

        if (pass_grant) begin
            ro_in_valid = pass_req;
            ro_in_beat  = ring_beat;
        end else begin
            ro_in_valid = local_grant && local_in_valid;
            ro_in_beat  = local_beat;
        end

        pass_xfer  = pass_grant && pass_req && ro_in_ready;
        local_xfer = local_grant && local_in_valid && ro_in_ready;

        ring_in_ready = 1'b0;
        case (ring_state)
            R_IDLE:  ring_in_ready = ring_drop || (ring_hdr && (hdr_local ? lo_in_ready
                                                                          : (pass_grant && ro_in_ready)));
            R_LOCAL: ring_in_ready = lo_in_ready;
            R_PASS:  ring_in_ready = pass_grant && ro_in_ready;
            default: ring_in_ready = 1'b0;
        endcase

        local_in_ready = 1'b0;
        case (arb_state)
            A_IDLE:  local_in_ready = local_drop || (local_wins && ro_in_ready);
            A_LOCAL: local_in_ready = ro_in_ready;
            default: local_in_ready = 1'b0;
        endcase
        ring_fire = ring_in_valid && ring_in_ready;
    end

    always_comb begin
        ring_state_next = ring_state;
        arb_state_next  = arb_state;
        burst_cnt_next  = burst_cnt;

        if (ring_fire) begin
            if (ring_in_endofpacket) begin
                ring_state_next = R_IDLE;
            end else if (ring_hdr) begin
                ring_state_next = hdr_local ? R_LOCAL : R_PASS;
            end
        end

        if (pass_xfer) begin
            arb_state_next = ring_in_endofpacket ? A_IDLE : A_PASS;
        end else if (local_xfer) begin
            arb_state_next = local_in_endofpacket ? A_IDLE : A_LOCAL;
        end

        // A pass completion only counts toward the burst limit while a local packet is starved.
        if (pass_xfer && ring_in_endofpacket) begin
            if (local_req) begin
                burst_cnt_next = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 4'd1;
            end else begin
                burst_cnt_next = 4'd0;
            end
        end else if (local_xfer && local_in_endofpacket) begin
            burst_cnt_next = 4'd0;
        end

        drop_inc  = {1'b0, ring_drop} + {1'b0, local_drop};
        drop_sum  = {1'b0, drop_count} + DW1'(drop_inc);
        drop_next = drop_sum[DW1-1] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            ring_state <= R_IDLE;
            arb_state  <= A_IDLE;
            burst_cnt  <= 4'd0;
            drop_count <= '0;
        end else begin
            ring_state <= ring_state_next;
            arb_state  <= arb_state_next;
            burst_cnt  <= burst_cnt_next;
            drop_count <= drop_next;
        end
    end

    dircc_st_reg_slice u_local_out (
        .clk       (clk_clk),
        .reset_n   (reset_reset_n),
        .in_valid  (lo_in_valid),
        .in_ready  (lo_in_ready),
        .in_beat   (ring_beat),
        .out_valid (local_out_valid),
        .out_beat  (lo_out_beat),
        .out_ready (local_out_ready)
    );

    dircc_st_reg_slice u_ring_out (
        .clk       (clk_clk),
        .reset_n   (reset_reset_n),
        .in_valid  (ro_in_valid),
        .in_ready  (ro_in_ready),
        .in_beat   (ro_in_beat),
        .out_valid (ring_out_valid),
        .out_beat  (ro_out_beat),
        .out_ready (ring_out_ready)
    );

    assign local_out_data          = lo_out_beat.data;
    assign local_out_startofpacket = lo_out_beat.sop;
    assign local_out_endofpacket   = lo_out_beat.eop;
    assign local_out_empty         = lo_out_beat.empty;
    assign ring_out_data           = ro_out_beat.data;
    assign ring_out_startofpacket  = ro_out_beat.sop;
    assign ring_out_endofpacket    = ro_out_beat.eop;
    assign ring_out_empty          = ro_out_beat.empty;

endmodule

// File: tb/tb_dircc_ring_router.sv
// Self-checking bench for dircc_ring_router: routing vector table, directed
// arbitration/backpressure/reset/saturation sequences, and a randomized scoreboard run.
module tb_dircc_ring_router;
    import dircc_ring_pkg::*;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [31:0] address_address;
    logic        ring_in_valid, ring_in_ready, ring_in_startofpacket, ring_in_endofpacket;
    logic [31:0] ring_in_data;
    logic [1:0]  ring_in_empty;
    logic        local_in_valid, local_in_ready, local_in_startofpacket, local_in_endofpacket;
    logic [31:0] local_in_data;
    logic [1:0]  local_in_empty;
    logic        local_out_valid, local_out_ready, local_out_startofpacket, local_out_endofpacket;
    logic [31:0] local_out_data;
    logic [1:0]  local_out_empty;
    logic        ring_out_valid, ring_out_ready, ring_out_startofpacket, ring_out_endofpacket;
    logic [31:0] ring_out_data;
    logic [1:0]  ring_out_empty;
    logic [15:0] drop_count;

    always #5 clk_clk = ~clk_clk;

    dircc_ring_router #(.MAX_PASS_BURST(4), .DROP_CNT_WIDTH(16)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .address_address(address_address),
        .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready), .ring_in_data(ring_in_data),
        .ring_in_startofpacket(ring_in_startofpacket), .ring_in_endofpacket(ring_in_endofpacket),
        .ring_in_empty(ring_in_empty),
        .local_in_valid(local_in_valid), .local_in_ready(local_in_ready), .local_in_data(local_in_data),
        .local_in_startofpacket(local_in_startofpacket), .local_in_endofpacket(local_in_endofpacket),
        .local_in_empty(local_in_empty),
        .local_out_valid(local_out_valid), .local_out_ready(local_out_ready),
        .local_out_data(local_out_data), .local_out_startofpacket(local_out_startofpacket),
        .local_out_endofpacket(local_out_endofpacket), .local_out_empty(local_out_empty),
        .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
        .ring_out_data(ring_out_data), .ring_out_startofpacket(ring_out_startofpacket),
        .ring_out_endofpacket(ring_out_endofpacket), .ring_out_empty(ring_out_empty),
        .drop_count(drop_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        exp_ready;
        logic        exp_local;
        logic        exp_ring;
        int          exp_drop_inc;
    } vec_t;

    vec_t     vecs[8];
    int       n_checks = 0;
    int       n_fails  = 0;
    int       exp_drop = 0;
    st_beat_t ring_tx[$], local_tx[$], ring_rx[$], local_rx[$];
    st_beat_t exp_pass[$], exp_lcl[$], exp_lo[$];

    function automatic st_beat_t mk(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
        st_beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.empty = emp;
        return b;
    endfunction

    function automatic st_beat_t lo_beat();
        return mk(local_out_data, local_out_startofpacket, local_out_endofpacket, local_out_empty);
    endfunction

    function automatic st_beat_t ro_beat();
        return mk(ring_out_data, ring_out_startofpacket, ring_out_endofpacket, ring_out_empty);
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive_ring(input st_beat_t b);
        ring_in_data = b.data; ring_in_startofpacket = b.sop;
        ring_in_endofpacket = b.eop; ring_in_empty = b.empty;
    endtask

    task automatic drive_local(input st_beat_t b);
        local_in_data = b.data; local_in_startofpacket = b.sop;
        local_in_endofpacket = b.eop; local_in_empty = b.empty;
    endtask

    task automatic applyStimulus(input vec_t v);
        address_address = v.addr;
        drive_ring(mk(v.data, v.sop, v.eop, v.empty));
        ring_in_valid   = 1'b1;
        local_in_valid  = 1'b0;
        local_out_ready = 1'b1;
        ring_out_ready  = 1'b1;
    endtask

    // Moves the tx queues through the DUT honouring valid/ready, logging every output beat.
    task automatic run_traffic(input int max_cycles, input bit rnd, input int stall_start,
                               input int stall_len, output int blocked);
        bit rf = 1'b0, lf = 1'b0, done = 1'b0;
        int cyc = 0;
        blocked = 0;
        ring_in_valid = 1'b0; local_in_valid = 1'b0;
        while (!done && cyc < max_cycles) begin
            @(posedge clk_clk); #1;
            if (rf) void'(ring_tx.pop_front());
            if (lf) void'(local_tx.pop_front());
            if (rf || !ring_in_valid) begin
                ring_in_valid = (ring_tx.size() > 0) && (!rnd || $urandom_range(3) != 0);
                if (ring_in_valid) drive_ring(ring_tx[0]);
            end
            if (lf || !local_in_valid) begin
                local_in_valid = (local_tx.size() > 0) && (!rnd || $urandom_range(3) != 0);
                if (local_in_valid) drive_local(local_tx[0]);
            end
            local_out_ready = !rnd || ($urandom_range(3) != 0);
            ring_out_ready  = !rnd || ($urandom_range(3) != 0);
            if (cyc >= stall_start && cyc < stall_start + stall_len) local_out_ready = 1'b0;
            #3;
            rf = ring_in_valid && ring_in_ready;
            lf = local_in_valid && local_in_ready;
            if (local_out_valid && local_out_ready) local_rx.push_back(lo_beat());
            if (ring_out_valid && ring_out_ready) ring_rx.push_back(ro_beat());
            if (!local_out_ready && ring_in_valid && !ring_in_ready) blocked++;
            done = (ring_tx.size() == 0) && (local_tx.size() == 0) && !local_out_valid && !ring_out_valid;
            cyc++;
        end
        ring_in_valid = 1'b0; local_in_valid = 1'b0;
        local_out_ready = 1'b1; ring_out_ready = 1'b1;
        checkOutput("traffic_drained", 64'(done), 64'd1);
    endtask

    initial begin
        int blocked;
        st_beat_t b;
        st_beat_t exp_seq[$];

        vecs[0] = '{32'h5,        32'h5,        1, 1, 2'd2, 1, 1, 0, 0};
        vecs[1] = '{32'h5,        32'h9,        1, 1, 2'd0, 1, 0, 1, 0};
        vecs[2] = '{32'h5,        32'h1234,     0, 0, 2'd1, 1, 0, 0, 1};
        vecs[3] = '{32'h77,       32'h5,        1, 1, 2'd3, 1, 0, 1, 0};
        vecs[4] = '{32'h77,       32'h77,       1, 1, 2'd3, 1, 1, 0, 0};
        vecs[5] = '{32'h5,        32'h5,        0, 1, 2'd0, 1, 0, 0, 1};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 2'd1, 1, 1, 0, 0};
        vecs[7] = '{32'h0,        32'h1,        1, 1, 2'd2, 1, 0, 1, 0};

        reset_reset_n = 1'b0; address_address = 32'h5;
        ring_in_valid = 0; ring_in_data = 0; ring_in_startofpacket = 0; ring_in_endofpacket = 0; ring_in_empty = 0;
        local_in_valid = 0; local_in_data = 0; local_in_startofpacket = 0; local_in_endofpacket = 0; local_in_empty = 0;
        local_out_ready = 1'b1; ring_out_ready = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        checkOutput("reset_local_out_valid", 64'(local_out_valid), 64'd0);
        checkOutput("reset_ring_out_valid", 64'(ring_out_valid), 64'd0);
        checkOutput("reset_drop_count", 64'(drop_count), 64'd0);
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("vec%0d_ring_in_ready", i), 64'(ring_in_ready), 64'(vecs[i].exp_ready));
            @(posedge clk_clk); #1;
            ring_in_valid = 1'b0;
            b = mk(vecs[i].data, vecs[i].sop, vecs[i].eop, vecs[i].empty);
            checkOutput($sformatf("vec%0d_local_out_valid", i), 64'(local_out_valid), 64'(vecs[i].exp_local));
            checkOutput($sformatf("vec%0d_ring_out_valid", i), 64'(ring_out_valid), 64'(vecs[i].exp_ring));
            if (vecs[i].exp_local) checkOutput($sformatf("vec%0d_local_beat", i), 64'(lo_beat()), 64'(b));
            if (vecs[i].exp_ring) checkOutput($sformatf("vec%0d_ring_beat", i), 64'(ro_beat()), 64'(b));
            exp_drop = sat_add(exp_drop, vecs[i].exp_drop_inc);
            checkOutput($sformatf("vec%0d_drop_count", i), 64'(drop_count), 64'(exp_drop));
            @(posedge clk_clk); #1;
        end

        $display("[TB] 3-beat packet to this node, one-cycle latency");
        address_address = 32'h5;
        for (int i = 0; i < 3; i++) begin
            b = mk((i == 0) ? 32'h5 : 32'h1111_0000 + 32'(i), i == 0, i == 2, (i == 2) ? 2'd2 : 2'd0);
            drive_ring(b);
            ring_in_valid = 1'b1;
            #3;
            checkOutput($sformatf("local_pkt_ready%0d", i), 64'(ring_in_ready), 64'd1);
            @(posedge clk_clk); #1;
            ring_in_valid = 1'b0;
            checkOutput($sformatf("local_pkt_valid%0d", i), 64'(local_out_valid), 64'd1);
            checkOutput($sformatf("local_pkt_beat%0d", i), 64'(lo_beat()), 64'(b));
            checkOutput($sformatf("local_pkt_ring_idle%0d", i), 64'(ring_out_valid), 64'd0);
        end
        @(posedge clk_clk); #1;
        checkOutput("local_pkt_no_extra", 64'(local_out_valid), 64'd0);

        $display("[TB] pass packet and local packet contend on the same cycle");
        ring_rx.delete(); local_rx.delete(); exp_seq.delete();
        for (int i = 0; i < 4; i++) begin
            b = mk((i == 0) ? 32'h9 : 32'h9900_0000 + 32'(i), i == 0, i == 3, 2'(i));
            ring_tx.push_back(b); exp_seq.push_back(b);
        end
        for (int i = 0; i < 2; i++) begin
            b = mk(32'hC0DE_0001 + 32'(i), i == 0, i == 1, 2'd1);
            local_tx.push_back(b); exp_seq.push_back(b);
        end
        run_traffic(200, 1'b0, -1, 0, blocked);
        checkOutput("contend_ring_count", 64'(ring_rx.size()), 64'd6);
        for (int i = 0; i < exp_seq.size() && i < ring_rx.size(); i++)
            checkOutput($sformatf("contend_beat%0d", i), 64'(ring_rx[i]), 64'(exp_seq[i]));

        $display("[TB] burst limit releases a starved local packet");
        ring_rx.delete(); exp_seq.delete();
        for (int i = 0; i < 6; i++) ring_tx.push_back(mk(32'hA000_0001 + 32'(i), 1, 1, 2'd0));
        local_tx.push_back(mk(32'hC000_0099, 1, 1, 2'd3));
        for (int i = 0; i < 4; i++) exp_seq.push_back(ring_tx[i]);
        exp_seq.push_back(local_tx[0]);
        for (int i = 4; i < 6; i++) exp_seq.push_back(ring_tx[i]);
        run_traffic(200, 1'b0, -1, 0, blocked);
        checkOutput("burst_ring_count", 64'(ring_rx.size()), 64'd7);
        for (int i = 0; i < exp_seq.size() && i < ring_rx.size(); i++)
            checkOutput($sformatf("burst_order%0d", i), 64'(ring_rx[i]), 64'(exp_seq[i]));

        $display("[TB] local_out stalled for 10 cycles mid-packet");
        ring_rx.delete(); local_rx.delete(); exp_seq.delete();
        for (int i = 0; i < 6; i++) begin
            b = mk((i == 0) ? 32'h5 : 32'h5500_0000 + 32'(i), i == 0, i == 5, 2'd1);
            ring_tx.push_back(b); exp_seq.push_back(b);
        end
        run_traffic(200, 1'b0, 2, 10, blocked);
        checkOutput("stall_backpressure_seen", 64'(blocked > 0), 64'd1);
        checkOutput("stall_local_count", 64'(local_rx.size()), 64'd6);
        checkOutput("stall_ring_quiet", 64'(ring_rx.size()), 64'd0);
        for (int i = 0; i < exp_seq.size() && i < local_rx.size(); i++)
            checkOutput($sformatf("stall_beat%0d", i), 64'(local_rx[i]), 64'(exp_seq[i]));

        $display("[TB] randomized traffic against scoreboard");
        ring_rx.delete(); local_rx.delete();
        for (int p = 0; p < 40; p++) begin
            int len;
            bit to_me;
            if ($urandom_range(5) == 0) begin
                ring_tx.push_back(mk($urandom, 1'b0, 1'($urandom_range(1)), 2'($urandom_range(3))));
                exp_drop = sat_add(exp_drop, 1);
            end
            len = $urandom_range(1, 4);
            to_me = ($urandom_range(4) < 2);
            for (int i = 0; i < len; i++) begin
                b = mk((i == 0) ? (to_me ? 32'h5 : {4'hA, 28'($urandom)}) : $urandom,
                       i == 0, i == len - 1, 2'($urandom_range(3)));
                ring_tx.push_back(b);
                if (to_me) exp_lo.push_back(b); else exp_pass.push_back(b);
            end
        end
        for (int p = 0; p < 30; p++) begin
            int len;
            if ($urandom_range(5) == 0) begin
                local_tx.push_back(mk($urandom, 1'b0, 1'($urandom_range(1)), 2'($urandom_range(3))));
                exp_drop = sat_add(exp_drop, 1);
            end
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                b = mk((i == 0) ? {4'hC, 28'($urandom)} : $urandom, i == 0, i == len - 1, 2'($urandom_range(3)));
                local_tx.push_back(b); exp_lcl.push_back(b);
            end
        end
        run_traffic(5000, 1'b1, -1, 0, blocked);
        foreach (local_rx[i]) begin
            if (exp_lo.size() == 0) checkOutput("rand_local_extra", 64'(local_rx[i]), 64'd0);
            else checkOutput("rand_local_beat", 64'(local_rx[i]), 64'(exp_lo.pop_front()));
        end
        begin
            int src = 0;
            foreach (ring_rx[i]) begin
                if (ring_rx[i].sop) src = (exp_pass.size() > 0 && ring_rx[i] == exp_pass[0]) ? 0 : 1;
                if (src == 0) checkOutput("rand_pass_beat", 64'(ring_rx[i]), 64'(exp_pass.pop_front()));
                else if (exp_lcl.size() == 0) checkOutput("rand_ring_extra", 64'(ring_rx[i]), 64'd0);
                else checkOutput("rand_local_to_ring_beat", 64'(ring_rx[i]), 64'(exp_lcl.pop_front()));
            end
        end
        checkOutput("rand_local_leftover", 64'(exp_lo.size()), 64'd0);
        checkOutput("rand_pass_leftover", 64'(exp_pass.size()), 64'd0);
        checkOutput("rand_lcl_leftover", 64'(exp_lcl.size()), 64'd0);
        checkOutput("rand_drop_count", 64'(drop_count), 64'(exp_drop));

        $display("[TB] reset asserted mid-packet");
        @(posedge clk_clk); #1;
        address_address = 32'h5;
        drive_ring(mk(32'h5, 1, 0, 0)); ring_in_valid = 1'b1;
        drive_local(mk(32'hC1, 1, 0, 0)); local_in_valid = 1'b1;
        @(posedge clk_clk); #1;
        drive_ring(mk(32'h2222, 0, 0, 0)); local_in_valid = 1'b0;
        @(posedge clk_clk); #1;
        ring_in_valid = 1'b0; reset_reset_n = 1'b0;
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;
        checkOutput("mid_reset_local_valid", 64'(local_out_valid), 64'd0);
        checkOutput("mid_reset_ring_valid", 64'(ring_out_valid), 64'd0);
        checkOutput("mid_reset_drop", 64'(drop_count), 64'd0);
        exp_drop = 0;
        drive_ring(mk(32'h9, 1, 1, 0)); ring_in_valid = 1'b1;
        #3;
        checkOutput("post_reset_pass_ready", 64'(ring_in_ready), 64'd1);
        @(posedge clk_clk); #1;
        checkOutput("post_reset_pass_routed", 64'({ring_out_valid, local_out_valid}), 64'b10);
        drive_ring(mk(32'h5, 1, 1, 2'd2));
        #3;
        checkOutput("post_reset_local_ready", 64'(ring_in_ready), 64'd1);
        @(posedge clk_clk); #1;
        ring_in_valid = 1'b0;
        checkOutput("post_reset_local_beat", 64'({local_out_valid, lo_beat()}), 64'({1'b1, mk(32'h5, 1, 1, 2'd2)}));
        @(posedge clk_clk); #1;

        $display("[TB] simultaneous orphans and drop counter saturation");
        drive_ring(mk(32'h0, 0, 0, 0)); ring_in_valid = 1'b1;
        drive_local(mk(32'h0, 0, 1, 0)); local_in_valid = 1'b1;
        #3;
        checkOutput("orphan_ring_ready", 64'(ring_in_ready), 64'd1);
        checkOutput("orphan_local_ready", 64'(local_in_ready), 64'd1);
        @(posedge clk_clk); #1;
        local_in_valid = 1'b0;
        exp_drop = sat_add(exp_drop, 2);
        checkOutput("dual_drop_count", 64'(drop_count), 64'(exp_drop));
        repeat (65539) @(posedge clk_clk);
        #1;
        exp_drop = sat_add(exp_drop, 65539);
        checkOutput("saturated_drop_count", 64'(drop_count), 64'(exp_drop));
        local_in_valid = 1'b1;
        @(posedge clk_clk); #1;
        ring_in_valid = 1'b0; local_in_valid = 1'b0;
        checkOutput("saturated_dual_drop", 64'(drop_count), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dircc_ring_router.md
Name: dircc_ring_router

Overview:
- Single ring-node router sitting between the network ring and one dircc_nios_processing element.
- Steers ring packets addressed to this node into the PE's stream_in. Forwards all other ring packets downstream.
- Injects the PE's stream_out packets onto the ring.
- All streams are Avalon-ST, 32-bit, with sop/eop/2-bit empty. Packet-granular arbitration and one registered stage per output.

Parameters:
MAX_PASS_BURST, 4, consecutive pass-through packets granted on ring_out while a local packet waits, before local is forced a grant (1..15).
DROP_CNT_WIDTH, 16, width of saturating orphan-beat drop counter.

Ports:
clk_clk  in  1  router clock (routing domain)
reset_reset_n  in  1  synchronous active-low reset
address_address  in  32  this node's address; sampled on every header beat
ring_in_valid/ready  in/out  1/1  upstream ring handshake
ring_in_data  in  32  word; on sop beat = destination address
ring_in_startofpacket, ring_in_endofpacket  in  1,1  framing
ring_in_empty  in  2  empty bytes on eop beat
local_in_valid/data/startofpacket/endofpacket/empty  in  1/32/1/1/2  from PE stream_out
local_in_ready  out  1
local_out_valid/data/startofpacket/endofpacket/empty  out  1/32/1/1/2  to PE stream_in
local_out_ready  in  1
ring_out_valid/data/startofpacket/endofpacket/empty  out  1/32/1/1/2  downstream ring
ring_out_ready  in  1
drop_count  out  DROP_CNT_WIDTH  orphan ring_in beats discarded, saturating

Behaviour:
- Reset: all *_valid=0, data/sop/eop/empty regs=0, drop_count=0, ingress=R_IDLE, arbiter=A_IDLE, burst counter=0.
- Reset mid-packet truncates in flight. No eop is synthesized.
- Output stage, per output:
  - Single register. Loads when !valid || ready.
  - Latency from input acceptance to output valid is exactly 1 cycle.
  - Full throughput, 1 beat/cycle, under continuous ready.
- Ingress FSM, on ring_in:
  - R_IDLE, valid && sop:
    - data == address_address → R_LOCAL.
    - Otherwise → R_PASS.
    - The header beat itself follows the selected route.
  - R_IDLE, valid && !sop: orphan. ready=1, beat discarded, drop_count+1, saturating at all-ones.
  - R_LOCAL: beats go to local_out. ring_in_ready = local_out stage can load.
  - R_PASS: beats are offered to the arbiter as source PASS. ready = grant && ring_out stage can load.
  - On accepted eop beat (including a single-beat sop&&eop) → R_IDLE. Route decision is still made on that beat.
  - sop seen while in R_LOCAL/R_PASS: no re-decode. Carried as a flag on the current route.
  - Header-beat ready in R_IDLE equals the ready of the chosen destination, so the decision is combinational on data. No extra latency.
- Arbiter FSM, on ring_out:
  - A_IDLE: requests are PASS (ingress routing a pass header or in R_PASS) and LOCAL (local_in_valid && sop).
  - Priority:
    - PASS wins unless LOCAL is requesting and burst counter == MAX_PASS_BURST.
    - Then LOCAL wins and the counter clears.
  - Grant is held (A_PASS / A_LOCAL) from the sop beat through the accepted eop beat, then → A_IDLE.
  - A granted header beat transfers in the same cycle as the grant decision.
  - Burst counter:
    - +1 on each completed PASS packet while LOCAL is waiting.
    - Clears on LOCAL packet completion.
    - Clears when no LOCAL is waiting at a PASS completion.
  - local_in beat with !sop while arbiter is not in A_LOCAL: orphan. Accepted and discarded, drop_count+1.
  - local_in_ready = 0 while A_PASS, or while A_IDLE without a LOCAL grant.
- empty is passed unchanged on all beats. Downstream ignores it except on eop.
- address_address change mid-packet affects only later headers.
- Simultaneous drops from both inputs in one cycle: drop_count +2, saturating.

Decomposition:
- Package dircc_ring_pkg:
  - st_beat_t struct {data[31:0], sop, eop, empty[1:0]}.
  - Enums ingress_state_t {R_IDLE, R_LOCAL, R_PASS} and arb_state_t {A_IDLE, A_PASS, A_LOCAL}.
  - Constant ST_EMPTY_W=2.
- Sub-module dircc_st_reg_slice: a one-deep registered stage of st_beat_t with valid/ready. Instantiated twice (local_out, ring_out).

Test Plan:
- address_address=0x5; ring_in 3-beat packet header 0x5 → appears on local_out 1 cycle after each accept, sop on beat0, eop+empty=2 on beat2; ring_out stays idle.
- Ring header 0x9, 4 beats, while local_in presents a 2-beat packet the same cycle → ring packet fully emitted first, then local packet. There is no interleaving on ring_out.
- MAX_PASS_BURST=4, continuous pass traffic of 1-beat packets plus a pending local packet → local granted after exactly 4 pass packets; burst counter then 0.
- local_out_ready=0 for 10 cycles during an R_LOCAL packet → ring_in_ready=0 after local_out stage fills; no beat is lost or duplicated after ready returns.
- ring_in beat valid, !sop, in R_IDLE → ready=1, drop_count 0→1. Force 2^16+3 orphans → drop_count holds 0xFFFF.
- reset_reset_n low for 1 cycle mid-packet → next cycle all valids 0, states idle. A new header 0x5 routes correctly.
